// File: rtl/fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_buffer
//
// Instruction prefetch buffer sitting between the instruction memory port and
// the decode stage. It issues sequential fetch requests ahead of decode, keeps
// up to DEPTH returned instructions together with their PCs, and presents the
// oldest one through a valid/ready handshake. A redirect (flush_i) empties the
// buffer, restarts fetching at flush_pc_i and silently drops the responses of
// requests that were already in flight.
//
// Optional feature macro: PREFETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target still flushes, but sets
//               misaligned_o and blocks further requests until an aligned
//               redirect or reset.
//   undefined : flush_pc_i[1:0] is ignored (treated as 2'b00), misaligned_o = 0.
//
// Parameters
//   XLEN             address / PC width
//   DEPTH            instruction slots (power of two, >= 2)
//   MAX_OUTSTANDING  max issued-but-unanswered requests (1..DEPTH)
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous active-low reset
//   run            fetch enable; 0 stops new requests, responses still accepted
//   flush_i        redirect strobe
//   flush_pc_i     redirect target, sampled while flush_i = 1
//   fetch_en_o     request valid
//   fetch_addr_o   request address
//   fetch_gnt_i    request accepted this cycle
//   fetch_valid_i  response valid (responses return in request order)
//   fetch_data_i   response instruction word
//   instr_valid_o  head entry valid
//   instr_o        head instruction
//   pc_o           PC of the head instruction
//   instr_ready_i  decode accepts the head entry
//   count_o        number of entries held
//   misaligned_o   misaligned redirect flag
// -----------------------------------------------------------------------------
module fetch_prefetch_buffer #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            flush_pc_i,
  output logic                       fetch_en_o,
  output logic [XLEN-1:0]            fetch_addr_o,
  input  logic                       fetch_gnt_i,
  input  logic                       fetch_valid_i,
  input  logic [31:0]                fetch_data_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            pc_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       misaligned_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);  // counters: 0..DEPTH
  localparam int unsigned PW = $clog2(DEPTH);      // FIFO pointers

  localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   MAX_OUT_W  = CW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]     r_instr_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_next_pc;      // address of the next request to issue
  logic [XLEN-1:0] r_resp_pc;      // PC belonging to the next kept response
  logic [CW-1:0]   r_outstanding;  // granted requests not yet answered
  logic [CW-1:0]   r_discard;      // in-flight responses to drop after a flush
  logic            r_misaligned;
  logic            r_started;      // holds requests off until the first edge out of reset

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [XLEN-1:0] w_next_pc_nxt;
  logic [XLEN-1:0] w_resp_pc_nxt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic            w_misaligned_nxt;

  // ---------------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------------
  logic            w_room;
  logic            w_fetch_en;
  logic            w_grant;
  logic            w_resp;
  logic            w_keep;
  logic            w_pop;
  logic            w_head_valid;
  logic [XLEN-1:0] w_flush_pc;
  logic            w_flush_mis;

`ifdef PREFETCH_MISALIGN_CHECK_EN
  assign w_flush_pc  = flush_pc_i;
  assign w_flush_mis = |flush_pc_i[1:0];
`else
  assign w_flush_pc  = flush_pc_i & ~XLEN'(3);
  assign w_flush_mis = 1'b0;
`endif

  // Space is reserved at request time: every in-flight request (kept or to be
  // discarded) owns a slot, so a returning response can never overflow.
  assign w_room       = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_W;
  assign w_fetch_en   = r_started & run & ~flush_i & ~r_misaligned & w_room &
                        (r_outstanding < MAX_OUT_W);
  assign w_grant      = w_fetch_en & fetch_gnt_i;
  // A response with nothing outstanding is a protocol error; ignoring it keeps
  // the counters from wrapping.
  assign w_resp       = fetch_valid_i & (r_outstanding != '0);
  // A response landing in the flush cycle belongs to the old stream.
  assign w_keep       = w_resp & (r_discard == '0) & ~flush_i;
  assign w_head_valid = (r_count != '0);
  // Flush wins over a same-cycle pop.
  assign w_pop        = w_head_valid & instr_ready_i & ~flush_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can leave
    // it unassigned, which would otherwise infer a latch.
    w_rd_ptr_nxt      = r_rd_ptr;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_count_nxt       = r_count;
    w_next_pc_nxt     = r_next_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(w_resp);
    w_discard_nxt     = r_discard;
    w_misaligned_nxt  = r_misaligned;

    if (w_grant) begin
      w_next_pc_nxt = r_next_pc + INSTR_STEP;
    end

    if (w_resp && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end

    if (w_keep) begin
      w_wr_ptr_nxt  = r_wr_ptr + PW'(1);
      w_resp_pc_nxt = r_resp_pc + INSTR_STEP;
    end

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end

    w_count_nxt = r_count + CW'(w_keep) - CW'(w_pop);

    if (flush_i) begin
      // Everything still in flight after this cycle's accounting is stale.
      w_rd_ptr_nxt     = '0;
      w_wr_ptr_nxt     = '0;
      w_count_nxt      = '0;
      w_next_pc_nxt    = w_flush_pc;
      w_resp_pc_nxt    = w_flush_pc;
      w_discard_nxt    = w_outstanding_nxt;
      w_misaligned_nxt = w_flush_mis;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_next_pc     <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_misaligned  <= 1'b0;
      r_started     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_count       <= w_count_nxt;
      r_next_pc     <= w_next_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      r_misaligned  <= w_misaligned_nxt;
      r_started     <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction storage
  // ---------------------------------------------------------------------------
  // NOTE: the slot array has no reset; a slot is only read after it has been
  // written, and the outputs are gated by the (reset) occupancy count.
  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_instr_mem[r_wr_ptr] <= fetch_data_i;
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fetch_en_o    = w_fetch_en;
  assign fetch_addr_o  = r_next_pc;
  assign instr_valid_o = w_head_valid;
  assign instr_o       = w_head_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign pc_o          = w_head_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign count_o       = r_count;
  assign misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_buffer
//
// Self-checking bench for fetch_prefetch_buffer (DEPTH=4, MAX_OUTSTANDING=2,
// RESET_PC=0). An in-order memory model answers granted requests after a
// random delay. The reference model is a queue of the instructions decode
// should see next, plus the list of in-flight addresses with a "stale" mark
// set by redirects. Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          flush_i;
  logic [31:0]   flush_pc_i;
  logic          fetch_en_o;
  logic [31:0]   fetch_addr_o;
  logic          fetch_gnt_i;
  logic          fetch_valid_i;
  logic [31:0]   fetch_data_i;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_o;
  logic          instr_ready_i;
  logic [CW-1:0] count_o;
  logic          misaligned_o;

  fetch_prefetch_buffer #(
    .XLEN           (32),
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC       (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .run          (run),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .fetch_en_o   (fetch_en_o),
    .fetch_addr_o (fetch_addr_o),
    .fetch_gnt_i  (fetch_gnt_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_data_i (fetch_data_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .instr_ready_i(instr_ready_i),
    .count_o      (count_o),
    .misaligned_o (misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model enable: answer the oldest pending request this cycle.
  bit resp_en;

  // Reference model
  ent_t        exp_q[$];
  logic [31:0] mem_addr_q[$];
  bit          mem_stale_q[$];
  logic [31:0] m_next_pc;
  bit          m_mis;
  bit          m_started;

  // Per-cycle snapshots of DUT outputs and model expectations
  logic          obs_en, obs_valid, obs_mis;
  logic [31:0]   obs_addr, obs_instr, obs_pc;
  logic [CW-1:0] obs_count;
  logic          exp_en, exp_valid, exp_mis;
  logic [31:0]   exp_addr, exp_instr, exp_pc;
  int            exp_count;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] redirect_pc(input logic [31:0] a);
`ifdef PREFETCH_MISALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic bit redirect_mis(input logic [31:0] a);
`ifdef PREFETCH_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle, entered and left at a falling edge: memory drives its
  // response, outputs are snapshotted with model expectations, the model
  // absorbs this cycle's handshakes.
  task automatic tick();
    logic [31:0] a;
    bit          s;
    bit          grant, pop;
    ent_t        e;
    a = '0;
    s = 1'b0;
    fetch_valid_i = resp_en && (mem_addr_q.size() != 0);
    fetch_data_i  = fetch_valid_i ? data_of(mem_addr_q[0]) : 32'h0;
    #1;
    obs_en    = fetch_en_o;
    obs_addr  = fetch_addr_o;
    obs_valid = instr_valid_o;
    obs_instr = instr_o;
    obs_pc    = pc_o;
    obs_count = count_o;
    obs_mis   = misaligned_o;

    exp_count = exp_q.size();
    exp_valid = (exp_q.size() != 0);
    exp_instr = exp_valid ? exp_q[0].instr : 32'h0;
    exp_pc    = exp_valid ? exp_q[0].pc : 32'h0;
    exp_en    = m_started && run && !flush_i && !m_mis &&
                (exp_q.size() + mem_addr_q.size() < DEPTH) &&
                (mem_addr_q.size() < MAXO);
    exp_addr  = m_next_pc;
    exp_mis   = m_mis;

    grant = obs_en && fetch_gnt_i;
    pop   = obs_valid && instr_ready_i;

    if (fetch_valid_i) begin
      a = mem_addr_q.pop_front();
      s = mem_stale_q.pop_front();
    end
    if (pop && !flush_i && exp_q.size() != 0) void'(exp_q.pop_front());
    if (fetch_valid_i && !s && !flush_i) begin
      e.instr = data_of(a);
      e.pc    = a;
      exp_q.push_back(e);
    end
    if (flush_i) begin
      exp_q.delete();
      foreach (mem_stale_q[i]) mem_stale_q[i] = 1'b1;
      m_next_pc = redirect_pc(flush_pc_i);
      m_mis     = redirect_mis(flush_pc_i);
    end
    if (grant) begin
      mem_addr_q.push_back(obs_addr);
      mem_stale_q.push_back(1'b0);
      m_next_pc = m_next_pc + 32'd4;
    end
    m_started = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q.delete();
    mem_addr_q.delete();
    mem_stale_q.delete();
    m_next_pc = 32'h0;
    m_mis     = 1'b0;
    m_started = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    run           = 1'b0;
    flush_i       = 1'b0;
    flush_pc_i    = 32'h0;
    fetch_gnt_i   = 1'b0;
    instr_ready_i = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = 32'h0;
    resp_en       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n       = 1'b0;
    run         = 1'b1;
    fetch_gnt_i = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({fetch_en_o, fetch_addr_o, instr_valid_o, instr_o, pc_o, count_o, misaligned_o} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, CW'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: en=%b addr=%h v=%b instr=%h pc=%h cnt=%0d mis=%b expected all zero",
               fetch_en_o, fetch_addr_o, instr_valid_o, instr_o, pc_o, count_o, misaligned_o);
    end
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    instr_ready_i = 1'b0;
    resp_en       = 1'b1;
    tick();
    n_cmp++;
    if (obs_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_no_req: fetch_en_o=%b expected 0", obs_en);
    end
    tick();
    n_cmp++;
    if (obs_en !== 1'b1 || obs_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL first_request: en=%b addr=%h expected en=1 addr=00000000", obs_en, obs_addr);
    end
    repeat (4) tick();
    // Asynchronous reset between edges must clear the buffer immediately.
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (count_o !== CW'(0) || instr_valid_o !== 1'b0 || fetch_addr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: cnt=%0d v=%b addr=%h expected 0 0 00000000",
               count_o, instr_valid_o, fetch_addr_o);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int k = 0;
    int p = 0;
    do_reset();
    run = 1'b1; fetch_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_en = 1'b1;
    repeat (20) begin
      tick();
      if (obs_en && fetch_gnt_i) begin
        n_cmp++;
        if (obs_addr !== 32'(k * 4)) begin
          n_bad++;
          $display("FAIL stream_addr: got %h expected %h", obs_addr, 32'(k * 4));
        end
        k++;
      end
      if (obs_valid) begin
        n_cmp++;
        if (obs_pc !== 32'(p * 4) || obs_instr !== data_of(32'(p * 4))) begin
          n_bad++;
          $display("FAIL stream_pc: got pc=%h instr=%h expected pc=%h instr=%h",
                   obs_pc, obs_instr, 32'(p * 4), data_of(32'(p * 4)));
        end
        p++;
      end
      n_cmp++;
      if (obs_count > CW'(1)) begin
        n_bad++;
        $display("FAIL stream_count: got %0d expected <= 1", obs_count);
      end
    end
    n_cmp++;
    if (k != 19 || p != 17) begin
      n_bad++;
      $display("FAIL stream_rate: requests=%0d pops=%0d expected 19 and 17", k, p);
    end
  endtask

  task automatic test_backpressure();
    int  p = 0;
    bit  resumed = 1'b0;
    do_reset();
    run = 1'b1; fetch_gnt_i = 1'b1; instr_ready_i = 1'b0; resp_en = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if (obs_count !== CW'(4) || obs_en !== 1'b0) begin
      n_bad++;
      $display("FAIL full_buffer: cnt=%0d en=%b expected cnt=4 en=0", obs_count, obs_en);
    end
    instr_ready_i = 1'b1;
    repeat (8) begin
      tick();
      if (obs_valid && p < 4) begin
        n_cmp++;
        if (obs_pc !== 32'(p * 4) || obs_instr !== data_of(32'(p * 4))) begin
          n_bad++;
          $display("FAIL drain_order: got pc=%h instr=%h expected pc=%h", obs_pc, obs_instr, 32'(p * 4));
        end
        p++;
      end
      if (obs_en) resumed = 1'b1;
    end
    n_cmp++;
    if (p != 4 || !resumed) begin
      n_bad++;
      $display("FAIL drain_resume: pops=%0d resumed=%b expected 4 and 1", p, resumed);
    end
  endtask

  task automatic test_flush_outstanding();
    logic [31:0] first_addr = 32'hFFFF_FFFF;
    logic [31:0] first_pc   = 32'hFFFF_FFFF;
    do_reset();
    run = 1'b1; fetch_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_en = 1'b0;
    repeat (3) tick();
    flush_i = 1'b1; flush_pc_i = 32'h100;
    tick();
    n_cmp++;
    if (obs_en !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_blocks_req: fetch_en_o=%b expected 0", obs_en);
    end
    flush_i = 1'b0; resp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 3) begin
        n_cmp++;
        if (obs_count !== CW'(0)) begin
          n_bad++;
          $display("FAIL flush_drop: cycle %0d count=%0d expected 0", i, obs_count);
        end
      end
      if (obs_en && first_addr === 32'hFFFF_FFFF) first_addr = obs_addr;
      if (obs_valid && first_pc === 32'hFFFF_FFFF) first_pc = obs_pc;
    end
    n_cmp++;
    if (first_addr !== 32'h100 || first_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL flush_restart: first addr=%h first pc=%h expected 00000100 00000100",
               first_addr, first_pc);
    end
  endtask

  task automatic test_flush_resp_pop();
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    do_reset();
    run = 1'b1; fetch_gnt_i = 1'b1; instr_ready_i = 1'b0; resp_en = 1'b0;
    repeat (3) tick();          // requests 0x0 and 0x4 in flight
    resp_en = 1'b1;
    tick();                     // 0x0 returns
    resp_en = 1'b0;
    tick();                     // request 0x8 issued, two in flight
    resp_en = 1'b1; instr_ready_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h40;
    tick();                     // 0x4 returns, head popped, flush: all collide
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL collide_setup: v=%b pc=%h expected 1 00000000", obs_valid, obs_pc);
    end
    flush_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 2) begin
        n_cmp++;
        if (obs_count !== CW'(0) || obs_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL collide_empty: cycle %0d cnt=%0d v=%b expected 0 0", i, obs_count, obs_valid);
        end
      end
      if (obs_valid && first_pc === 32'hFFFF_FFFF) first_pc = obs_pc;
    end
    n_cmp++;
    if (first_pc !== 32'h40) begin
      n_bad++;
      $display("FAIL collide_restart: first pc=%h expected 00000040", first_pc);
    end
  endtask

  task automatic test_gnt_low();
    do_reset();
    run = 1'b1; fetch_gnt_i = 1'b0; instr_ready_i = 1'b1; resp_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs_en !== 1'b1 || obs_addr !== 32'h0 || obs_count !== CW'(0)) begin
        n_bad++;
        $display("FAIL gnt_low: cycle %0d en=%b addr=%h cnt=%0d expected 1 00000000 0",
                 i, obs_en, obs_addr, obs_count);
      end
    end
    fetch_gnt_i = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL gnt_release: v=%b pc=%h expected 1 00000000", obs_valid, obs_pc);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] first_addr = 32'hFFFF_FFFF;
    do_reset();
    run = 1'b1; fetch_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_en = 1'b1;
    repeat (4) tick();
    flush_i = 1'b1; flush_pc_i = 32'h102;
    tick();
    flush_i = 1'b0;
`ifdef PREFETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (obs_mis !== 1'b1 || obs_en !== 1'b0) begin
        n_bad++;
        $display("FAIL misaligned_block: cycle %0d mis=%b en=%b expected 1 0", i, obs_mis, obs_en);
      end
    end
    flush_i = 1'b1; flush_pc_i = 32'h200;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_en && first_addr === 32'hFFFF_FFFF) first_addr = obs_addr;
    end
    n_cmp++;
    if (obs_mis !== 1'b0 || first_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL misaligned_clear: mis=%b first addr=%h expected 0 00000200", obs_mis, first_addr);
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_en && first_addr === 32'hFFFF_FFFF) first_addr = obs_addr;
    end
    n_cmp++;
    if (obs_mis !== 1'b0 || first_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL misaligned_ignored: mis=%b first addr=%h expected 0 00000100", obs_mis, first_addr);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      run           = ($urandom_range(0, 9) != 0);
      fetch_gnt_i   = ($urandom_range(0, 3) != 0);
      instr_ready_i = ($urandom_range(0, 2) != 0);
      resp_en       = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      flush_pc_i    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) flush_pc_i = 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) flush_pc_i = flush_pc_i | 32'($urandom_range(1, 3));
      tick();
      n_cmp++;
      if (obs_count !== CW'(exp_count) || obs_valid !== exp_valid) begin
        n_bad++;
        $display("FAIL rnd_occupancy: cycle %0d cnt=%0d v=%b expected cnt=%0d v=%b",
                 c, obs_count, obs_valid, exp_count, exp_valid);
      end
      n_cmp++;
      if (obs_en !== exp_en || obs_mis !== exp_mis) begin
        n_bad++;
        $display("FAIL rnd_request: cycle %0d en=%b mis=%b expected en=%b mis=%b",
                 c, obs_en, obs_mis, exp_en, exp_mis);
      end
      if (exp_en && obs_en) begin
        n_cmp++;
        if (obs_addr !== exp_addr) begin
          n_bad++;
          $display("FAIL rnd_addr: cycle %0d got %h expected %h", c, obs_addr, exp_addr);
        end
      end
      if (exp_valid && obs_valid) begin
        n_cmp++;
        if (obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          n_bad++;
          $display("FAIL rnd_head: cycle %0d pc=%h instr=%h expected pc=%h instr=%h",
                   c, obs_pc, obs_instr, exp_pc, exp_instr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_outstanding();
    test_flush_resp_pop();
    test_gnt_low();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
